// File: rtl/mk14_display_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mk14_display_scan
//  Description : Time-multiplexed scanner for an eight-digit seven-segment
//                display (segments a..g plus dp). Each digit is lit for
//                DIGIT_US microseconds and is preceded by BLANK_US
//                microseconds with every output inactive, so two digits are
//                never driven together. frame_done pulses once per
//                eight-digit scan.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1   system clock
//    rst_n       in   1   synchronous active-low reset
//    display     in  64   segment bytes, digit n = display[8n+7:8n]
//                         (bit0 = segment a ... bit7 = dp)
//    seg         out  8   segment drive for the lit digit (registered)
//    digit_sel   out  8   one-hot digit enable, bit n = digit n (registered)
//    frame_done  out  1   one-cycle pulse in the first blank cycle after
//                         digit 7 has been lit (registered)
//  Parameters
//    CLOCK_FREQ_MHZ  clock ticks per microsecond
//    DIGIT_US        on-time per digit, microseconds (>= 1)
//    BLANK_US        inter-digit blanking, microseconds (>= 1)
//    ACTIVE_LOW      1 = seg and digit_sel are driven inverted
//  Build option
//    MK14_DISPLAY_SNAPSHOT_EN  when defined, all 64 display bits are captured
//                              once per frame and seg is sourced only from
//                              that frame buffer; otherwise seg follows the
//                              live display input with one cycle of latency.
// ============================================================================
module mk14_display_scan #(
    parameter int CLOCK_FREQ_MHZ = 50,
    parameter int DIGIT_US       = 1000,
    parameter int BLANK_US       = 10,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] display,
    output logic [7:0]  seg,
    output logic [7:0]  digit_sel,
    output logic        frame_done
);

    localparam int ON_CYCLES    = DIGIT_US * CLOCK_FREQ_MHZ;
    localparam int BLANK_CYCLES = BLANK_US * CLOCK_FREQ_MHZ;
    localparam int MAX_CYCLES   = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W        = $clog2(MAX_CYCLES + 1);

    // Phase loads are N-1 because the entry cycle itself counts as one.
    // The reset load is N because the reset cycle is not part of the
    // blanking period; this puts the first lit cycle exactly BLANK_CYCLES
    // cycles after reset release.
    localparam logic [CNT_W-1:0] ON_LOAD     = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_RESET = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Inactive output level; XOR with it applies the polarity at the flops.
    localparam logic [7:0] OFF_LEVEL = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       digit;
    logic [63:0]      seg_src;
    logic [7:0]       lit_seg;
    logic [7:0]       lit_sel;

`ifdef MK14_DISPLAY_SNAPSHOT_EN
    logic [63:0] frame_buf;
    logic        rst_seen;
    logic        first_after_rst;
    logic        capture;

    // Capture in the first blank cycle of digit 0: the cycle right after
    // reset release, or the cycle where frame_done is high.
    assign capture = (state == S_BLANK) && (digit == 3'd0)
                     && (frame_done || first_after_rst);

    always_ff @(posedge clk) begin
        rst_seen        <= ~rst_n;
        first_after_rst <= rst_n & rst_seen;
        if (rst_n && capture) begin
            frame_buf <= display;
        end
    end

    // Forward the value being captured so a one-cycle blank period still
    // lights digit 0 with the fresh snapshot.
    assign seg_src = capture ? display : frame_buf;
`else
    assign seg_src = display;
`endif

    assign lit_seg = seg_src[{digit, 3'b000} +: 8];
    assign lit_sel = 8'b0000_0001 << digit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_BLANK;
            digit      <= 3'd0;
            cnt        <= BLANK_RESET;
            frame_done <= 1'b0;
            seg        <= OFF_LEVEL;
            digit_sel  <= OFF_LEVEL;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_BLANK: begin
                    if (cnt == '0) begin
                        state     <= S_ON;
                        cnt       <= ON_LOAD;
                        seg       <= lit_seg ^ OFF_LEVEL;
                        digit_sel <= lit_sel ^ OFF_LEVEL;
                    end else begin
                        cnt       <= cnt - CNT_ONE;
                        seg       <= OFF_LEVEL;
                        digit_sel <= OFF_LEVEL;
                    end
                end
                S_ON: begin
                    if (cnt == '0) begin
                        state      <= S_BLANK;
                        cnt        <= BLANK_LOAD;
                        digit      <= digit + 3'd1;
                        frame_done <= (digit == 3'd7);
                        seg        <= OFF_LEVEL;
                        digit_sel  <= OFF_LEVEL;
                    end else begin
                        cnt       <= cnt - CNT_ONE;
                        seg       <= lit_seg ^ OFF_LEVEL;
                        digit_sel <= lit_sel ^ OFF_LEVEL;
                    end
                end
                default: begin
                    state     <= S_BLANK;
                    cnt       <= BLANK_LOAD;
                    seg       <= OFF_LEVEL;
                    digit_sel <= OFF_LEVEL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mk14_display_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mk14_display_scan
//  Description : Self-checking bench for mk14_display_scan with
//                CLOCK_FREQ_MHZ=2, DIGIT_US=3, BLANK_US=1 (6 on, 2 blank,
//                64-cycle frame). Two instances run side by side, one per
//                output polarity. A cycle-position model predicts every
//                output; directed literal checks pin the model.
//                Honours MK14_DISPLAY_SNAPSHOT_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mk14_display_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] display;
    logic [63:0] display_inv;
    logic [7:0]  seg, digit_sel, seg_i, sel_i;
    logic        frame_done, frame_done_i;

    mk14_display_scan #(
        .CLOCK_FREQ_MHZ(2), .DIGIT_US(3), .BLANK_US(1), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .display(display),
        .seg(seg), .digit_sel(digit_sel), .frame_done(frame_done)
    );

    mk14_display_scan #(
        .CLOCK_FREQ_MHZ(2), .DIGIT_US(3), .BLANK_US(1), .ACTIVE_LOW(1)
    ) dut_inv (
        .clk(clk), .rst_n(rst_n), .display(display_inv),
        .seg(seg_i), .digit_sel(sel_i), .frame_done(frame_done_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit run_cmp  = 1'b0;

    // Model state: k = number of rising edges with rst_n high since the last
    // reset edge; display as seen at the most recent edge.
    int          k = 0;
    logic [63:0] samp, samp_i;
`ifdef MK14_DISPLAY_SNAPSHOT_EN
    logic [63:0] snap, snap_i;
`endif

    always @(posedge clk) begin
        if (!rst_n) k = 0;
        else        k = k + 1;
        samp   = display;
        samp_i = display_inv;
`ifdef MK14_DISPLAY_SNAPSHOT_EN
        // Snapshot taken at the edge that ends the first blank cycle of a frame.
        if (k >= 1 && ((k - 1) % 64) == 1) begin
            snap   = display;
            snap_i = display_inv;
        end
`endif
    end

    // Frame position q = (k-1) mod 64: slot q/8 is the digit, first two
    // cycles of each slot are blank, frame_done marks q==0 of a later frame.
    task automatic model_out(input int kk, input logic [63:0] src,
                             output logic [7:0] es, output logic [7:0] esel,
                             output logic efd);
        int q;
        int d;
        es = 8'h00; esel = 8'h00; efd = 1'b0;
        if (kk >= 1) begin
            q = (kk - 1) % 64;
            d = q / 8;
            if ((q % 8) >= 2) begin
                esel = 8'(1 << d);
                es   = src[d*8 +: 8];
            end
            efd = (q == 0) && (kk > 1);
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (k=%0d)", name, act, exp, k);
        end
    endtask

    logic [7:0] prev_sel = 8'h00;

    always @(negedge clk) begin
        logic [7:0]  es, esel, es_i, esel_i;
        logic        efd, efd_i;
        logic [63:0] src, src_i;
        bit          ok;
        if (run_cmp) begin
`ifdef MK14_DISPLAY_SNAPSHOT_EN
            src = snap;  src_i = snap_i;
`else
            src = samp;  src_i = samp_i;
`endif
            model_out(k, src, es, esel, efd);
            model_out(k, src_i, es_i, esel_i, efd_i);
            check("seg", seg, es);
            check("digit_sel", digit_sel, esel);
            check("frame_done", {7'b0, frame_done}, {7'b0, efd});
            check("seg_inv", seg_i, ~es_i);
            check("digit_sel_inv", sel_i, ~esel_i);
            check("frame_done_inv", {7'b0, frame_done_i}, {7'b0, efd_i});
            ok = ($countones(digit_sel) <= 1)
                 && !(prev_sel != 8'h00 && digit_sel != 8'h00 && prev_sel != digit_sel);
            check("overlap", {7'b0, ok}, 8'h01);
            prev_sel = digit_sel;
        end
    end

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (k != target && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (k != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_to: k=%0d expected %0d", k, target);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        display     = 64'h0706050403020100;
        display_inv = 64'h070605040302013F;
        repeat (3) @(negedge clk);
        run_cmp = 1'b1;

        // Reset state
        check("rst_seg", seg, 8'h00);
        check("rst_sel", digit_sel, 8'h00);
        check("rst_fd", {7'b0, frame_done}, 8'h00);
        check("rst_seg_inv", seg_i, 8'hFF);
        check("rst_sel_inv", sel_i, 8'hFF);

        // Release: two blank cycles, then digit 0
        rst_n = 1'b1;
        @(negedge clk);
        check("rel1_sel", digit_sel, 8'h00);
        check("rel1_seg_inv", seg_i, 8'hFF);
        check("rel1_sel_inv", sel_i, 8'hFF);
        run_to(2);
        check("rel2_sel", digit_sel, 8'h00);
        run_to(3);
        check("d0_sel", digit_sel, 8'h01);
        check("d0_seg", seg, 8'h00);
        check("d0_seg_inv", seg_i, 8'hC0);
        check("d0_sel_inv", sel_i, 8'hFE);
        run_to(8);
        check("d0_last_sel", digit_sel, 8'h01);
        run_to(9);
        check("blank_a_sel", digit_sel, 8'h00);
        run_to(10);
        check("blank_b_sel", digit_sel, 8'h00);
        run_to(11);
        check("d1_sel", digit_sel, 8'h02);
        check("d1_seg", seg, 8'h01);

        // Wrap
        run_to(64);
        check("d7_seg", seg, 8'h07);
        check("d7_sel", digit_sel, 8'h80);
        check("d7_fd", {7'b0, frame_done}, 8'h00);
        run_to(65);
        check("wrap_fd", {7'b0, frame_done}, 8'h01);
        check("wrap_sel", digit_sel, 8'h00);
        run_to(66);
        check("wrap_fd_off", {7'b0, frame_done}, 8'h00);
        run_to(67);
        check("wrap_d0_sel", digit_sel, 8'h01);

        // Change digit 1 while digit 0 is lit
        run_to(68);
        display[15:8]     = 8'hFF;
        display_inv[15:8] = 8'hFF;
        run_to(75);
        check("chg_d1_sel", digit_sel, 8'h02);
`ifdef MK14_DISPLAY_SNAPSHOT_EN
        check("chg_d1_seg", seg, 8'h01);
`else
        check("chg_d1_seg", seg, 8'hFF);
`endif
        run_to(139);
        check("next_d1_seg", seg, 8'hFF);

        // Mid-frame reset during digit 4
        run_to(165);
        check("d4_sel", digit_sel, 8'h10);
        check("d4_seg", seg, 8'h04);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_sel", digit_sel, 8'h00);
        check("mrst_seg", seg, 8'h00);
        check("mrst_fd", {7'b0, frame_done}, 8'h00);
        check("mrst_sel_inv", sel_i, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrel_sel", digit_sel, 8'h00);
        run_to(3);
        check("mrel_d0_sel", digit_sel, 8'h01);
        check("mrel_d0_seg", seg, 8'h00);

        // One more full frame under the per-cycle model
        run_to(80);
        run_cmp = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mk14_display_scan.md
MK14_DISPLAY_SCAN -- requirements
Module: mk14_display_scan

Interface
REQ-001 SHALL have parameter CLOCK_FREQ_MHZ, default 50, clock ticks per microsecond.
REQ-002 SHALL have parameter DIGIT_US, default 1000, on-time per digit in microseconds; legal range 1 or more.
REQ-003 SHALL have parameter BLANK_US, default 10, inter-digit blanking time in microseconds; legal range 1 or more.
REQ-004 SHALL have parameter ACTIVE_LOW, default 0; when 1, seg and digit_sel are driven inverted.
REQ-005 SHALL have port clk, input, 1 bit, system clock.
REQ-006 SHALL have port rst_n, input, 1 bit, reset (synchronous, active-low).
REQ-007 SHALL have port display, input, 64 bits, eight segment bytes; digit n = display[8n+7:8n], bit0 = segment a through bit7 = dp.
REQ-008 SHALL have port seg, output, 8 bits, segment drive for the lit digit.
REQ-009 SHALL have port digit_sel, output, 8 bits, one-hot digit enable; bit n lights digit n.
REQ-010 SHALL have port frame_done, output, 1 bit, one-cycle pulse at the end of each full 8-digit scan.

Function
REQ-011 SHALL derive ON_CYCLES = DIGIT_US*CLOCK_FREQ_MHZ and BLANK_CYCLES = BLANK_US*CLOCK_FREQ_MHZ at elaboration, with a single down-counter sized for the larger value.
REQ-012 SHALL implement two states: S_BLANK (digit_sel all inactive, seg all inactive) and S_ON (digit_sel bit[digit] active, seg = byte[digit]).
REQ-013 SHALL remain in S_BLANK for exactly BLANK_CYCLES cycles, then enter S_ON.
REQ-014 SHALL remain in S_ON for exactly ON_CYCLES cycles, then enter S_BLANK with digit = (digit+1) mod 8.
REQ-015 SHALL wrap digit from 7 to 0, giving a frame period of 8*(ON_CYCLES+BLANK_CYCLES) cycles.
REQ-016 SHALL pulse frame_done high for exactly one cycle, coincident with the first S_BLANK cycle after the S_ON of digit 7.
REQ-017 SHALL register seg, digit_sel and frame_done so that no output has a combinational path from display.
REQ-018 SHALL keep seg and digit_sel never simultaneously active for two different digits; every digit change passes through at least one S_BLANK cycle.
REQ-019 SHALL, in S_ON without snapshot, track changes on display with one cycle of latency.
REQ-020 SHALL apply ACTIVE_LOW inversion only at the output registers; internal state is polarity-independent.

Reset
REQ-021 SHALL, while rst_n is low at a rising clk edge, set state to S_BLANK, digit to 0, the counter to load BLANK_CYCLES, and frame_done to 0.
REQ-022 SHALL drive seg and digit_sel to their inactive level during reset: 0 if ACTIVE_LOW=0, all ones if ACTIVE_LOW=1.
REQ-023 SHALL treat reset asserted mid-frame identically to power-on reset, with no frame_done pulse generated.
REQ-024 SHALL have its first S_ON cycle BLANK_CYCLES cycles after the first cycle with rst_n high.

Configuration
REQ-025 SHALL support macro MK14_DISPLAY_SNAPSHOT_EN.
REQ-026 SHALL, when MK14_DISPLAY_SNAPSHOT_EN is defined, capture all 64 display bits into a frame buffer on the first S_BLANK cycle of digit 0 (after reset and after each frame_done), and source seg only from that buffer until the next capture.
REQ-027 SHALL, when MK14_DISPLAY_SNAPSHOT_EN is undefined, omit the frame buffer and source seg from the live display input per REQ-019.

Verification (CLOCK_FREQ_MHZ=2, DIGIT_US=3, BLANK_US=1: ON=6, BLANK=2, frame=64 cycles)
REQ-028 SHALL cover reset release: display=64'h0706050403020100 -> 2 cycles all inactive, then digit_sel=8'h01 and seg=8'h00 for 6 cycles, 2 blank, then digit_sel=8'h02 and seg=8'h01.
REQ-029 SHALL cover wrap: run 64 cycles -> frame_done high for exactly one cycle after digit 7 (seg=8'h07), next lit digit is digit_sel=8'h01.
REQ-030 SHALL cover mid-frame reset: assert rst_n low during digit 4 S_ON -> outputs inactive next edge, no frame_done, scan restarts at digit 0 after 2 blank cycles.
REQ-031 SHALL cover snapshot: change display[15:8] from 8'h01 to 8'hFF during digit 0 -> with MK14_DISPLAY_SNAPSHOT_EN, digit 1 shows 8'h01 and the next frame shows 8'hFF; without it, digit 1 shows 8'hFF.
REQ-032 SHALL cover polarity: ACTIVE_LOW=1 with display byte 0 = 8'h3F -> blanking shows seg=8'hFF and digit_sel=8'hFF; digit 0 shows seg=8'hC0 and digit_sel=8'hFE.
REQ-033 SHALL cover overlap: assertion over a full frame that popcount of active digit_sel is 1 or less and that each digit change passes through an all-inactive cycle.
